// File: rtl/tinyqv_intc.sv
// tinyqv_intc: parametrised interrupt controller for the nibble-serial TinyQV core.
// Holds the enable (MIE), pending (MIP) and trigger-mode registers and picks the
// winning channel when the core takes an interrupt. CSR traffic moves one nibble
// per counter step, with bit i carried on nibble i/4 at counter == i/4.
//
// Acknowledge handshake: take_irq is a one-cycle request that is only honoured at
// counter == 0. The clock after an honoured request, irq_cause/cause_valid are
// updated together and then hold until the next honoured request; there is no
// back-pressure, so the core must take the result at any time before then.

module tinyqv_intc #(
  parameter int          NUM_IRQ    = 16,
  parameter logic [31:0] MODE_RESET = 32'h0000_0003,
  parameter bit          AUTO_CLEAR = 1'b1,
  parameter logic [11:0] ADDR_MIE   = 12'h304,
  parameter logic [11:0] ADDR_MIP   = 12'h344,
  parameter logic [11:0] ADDR_MODE  = 12'hBC0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [2:0]         counter,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               global_ie,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [3:0]         csr_wdata,
  output logic [3:0]         csr_rdata,
  input  logic               take_irq,
  output logic               irq_pending,
  output logic [4:0]         irq_cause,
  output logic               cause_valid
);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [NUM_IRQ-1:0] enable_q, mode_q, edge_q, last_q;
  logic [NUM_IRQ-1:0] enable_n, mode_n, edge_n;
  logic [NUM_IRQ-1:0] pending, active;
  logic [NUM_IRQ-1:0] nib_mask, nib_bits, rd_word, win_oh;
  logic               sel_mie, sel_mip, sel_mode, ack, win_any;
  logic [4:0]         win_idx, cause_q;
  logic               cause_valid_q;

  // Apply a CSR write/set/clear to the nibble selected by the counter.
  function automatic logic [NUM_IRQ-1:0] csr_apply(
    input logic [1:0]         op,
    input logic [NUM_IRQ-1:0] old,
    input logic [NUM_IRQ-1:0] mask,
    input logic [NUM_IRQ-1:0] bits
  );
    case (op)
      OP_WRITE: return (old & ~mask) | bits;
      OP_SET:   return old | bits;
      OP_CLEAR: return old & ~bits;
      default:  return old;
    endcase
  endfunction

  // Counters past the last nibble shift everything out, so they read 0 and write nothing.
  assign nib_mask = NUM_IRQ'(4'hF) << {counter, 2'b00};
  assign nib_bits = NUM_IRQ'(csr_wdata) << {counter, 2'b00};

  assign sel_mie  = (csr_op != 2'b00) && (csr_addr == ADDR_MIE);
  assign sel_mip  = (csr_op != 2'b00) && (csr_addr == ADDR_MIP);
  assign sel_mode = (csr_op != 2'b00) && (csr_addr == ADDR_MODE);

  // Level channels follow the line directly; edge channels report their latch.
  assign pending     = (mode_q & edge_q) | (~mode_q & irq_in);
  assign active      = pending & enable_q;
  assign irq_pending = global_ie & (|active);
  assign ack         = take_irq && (counter == 3'd0);

  // Read path: pre-update register value, nibble picked by the counter.
  always_comb begin
    rd_word = '0;
    if (sel_mie)       rd_word = enable_q;
    else if (sel_mip)  rd_word = pending;
    else if (sel_mode) rd_word = mode_q;
    csr_rdata = 4'(rd_word >> {counter, 2'b00});
  end

  // Fixed priority: the lowest-numbered active channel wins.
  always_comb begin
    win_idx = 5'd0;
    win_any = 1'b0;
    win_oh  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_idx = 5'(i);
        win_any = 1'b1;
        win_oh  = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  // Next register values; hardware edges are applied after software clears so set wins.
  always_comb begin
    enable_n = sel_mie  ? csr_apply(csr_op, enable_q, nib_mask, nib_bits) : enable_q;
    mode_n   = sel_mode ? csr_apply(csr_op, mode_q, nib_mask, nib_bits) : mode_q;
    edge_n   = sel_mip  ? csr_apply(csr_op, edge_q, nib_mask, nib_bits) : edge_q;
    if (AUTO_CLEAR && ack) edge_n = edge_n & ~(win_oh & mode_q);
    edge_n = edge_n | (irq_in & ~last_q & mode_q);
    // Level channels never hold a latched edge, which also drops it on a mode change.
    edge_n = edge_n & mode_n;
  end

  // State registers and the acknowledge result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enable_q      <= '0;
      mode_q        <= MODE_RESET[NUM_IRQ-1:0];
      edge_q        <= '0;
      last_q        <= '0;
      cause_q       <= 5'd0;
      cause_valid_q <= 1'b0;
    end else begin
      enable_q <= enable_n;
      mode_q   <= mode_n;
      edge_q   <= edge_n;
      last_q   <= irq_in;
      if (ack) begin
        cause_q       <= win_any ? win_idx : 5'd0;
        cause_valid_q <= win_any;
      end
    end
  end

  assign irq_cause   = cause_q;
  assign cause_valid = cause_valid_q;

endmodule

// File: tb/tb_tinyqv_intc.sv
// Bench for tinyqv_intc: a 16-channel and a 32-channel instance share one set of
// stimulus. A per-bit reference model predicts every cycle's outputs into a queue
// that a monitor drains, and the directed scenarios add fixed-value checks.

module tb_tinyqv_intc;

  localparam logic [11:0] A_MIE  = 12'h304;
  localparam logic [11:0] A_MIP  = 12'h344;
  localparam logic [11:0] A_MODE = 12'hBC0;
  localparam logic [11:0] A_NONE = 12'h300;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  counter;
  logic [31:0] irq_in;
  logic        global_ie;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [3:0]  csr_wdata;
  logic        take_irq;

  logic [3:0]  rd16, rd32;
  logic        pend16, pend32, cv16, cv32;
  logic [4:0]  cause16, cause32;

  int vectors = 0;
  int errors  = 0;
  logic [21:0] exp_q[$];

  // Reference model state, index 0 = 16 channels, index 1 = 32 channels.
  logic [31:0] m_mie[2], m_mode[2], m_edge[2], m_last[2];
  logic [4:0]  m_cause[2];
  logic        m_cv[2];

  // Clock and reset block.
  always #5 clk = ~clk;

  tinyqv_intc #(.NUM_IRQ(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .counter(counter), .irq_in(irq_in[15:0]),
    .global_ie(global_ie), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(rd16), .take_irq(take_irq),
    .irq_pending(pend16), .irq_cause(cause16), .cause_valid(cv16)
  );

  tinyqv_intc #(.NUM_IRQ(32)) u_dut32 (
    .clk(clk), .rstn(rstn), .counter(counter), .irq_in(irq_in),
    .global_ie(global_ie), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(rd32), .take_irq(take_irq),
    .irq_pending(pend32), .irq_cause(cause32), .cause_valid(cv32)
  );

  function automatic logic apply_op(input logic [1:0] op, input logic old, input logic b);
    case (op)
      2'b01:   return b;
      2'b10:   return old | b;
      2'b11:   return old & ~b;
      default: return old;
    endcase
  endfunction

  // Reference model: predicts this cycle's outputs, then advances to the next clock.
  initial begin : model
    logic [31:0] pend, act, reg_sel;
    logic [3:0]  rd;
    logic        hit_reg, o_pend, ack, nm, ne, e, b, in_nib;
    logic [10:0] ow;
    logic [21:0] w;
    int          n, win;
    forever begin
      @(negedge clk);
      #1;
      w = '0;
      for (int k = 0; k < 2; k++) begin
        n = (k == 0) ? 16 : 32;
        if (!rstn) begin
          m_mie[k] = '0; m_mode[k] = 32'h3; m_edge[k] = '0; m_last[k] = '0;
          m_cause[k] = 5'd0; m_cv[k] = 1'b0;
        end
        pend = '0;
        for (int i = 0; i < n; i++) pend[i] = m_mode[k][i] ? m_edge[k][i] : irq_in[i];
        act    = pend & m_mie[k];
        o_pend = global_ie && (act != 0);
        hit_reg = 1'b1;
        case (csr_addr)
          A_MIE:   reg_sel = m_mie[k];
          A_MIP:   reg_sel = pend;
          A_MODE:  reg_sel = m_mode[k];
          default: begin reg_sel = '0; hit_reg = 1'b0; end
        endcase
        rd = 4'h0;
        if (csr_op != 2'b00 && hit_reg && int'(counter) < n / 4)
          for (int j = 0; j < 4; j++) rd[j] = reg_sel[int'(counter) * 4 + j];
        ow = {rd, o_pend, m_cv[k], m_cause[k]};
        w[k*11 +: 11] = ow;
        if (rstn) begin
          ack = take_irq && counter == 3'd0;
          win = -1;
          for (int i = 0; i < n; i++) if (act[i] && win < 0) win = i;
          for (int i = 0; i < n; i++) begin
            in_nib = (csr_op != 2'b00) && (int'(counter) == i / 4);
            b  = csr_wdata[i % 4];
            nm = (in_nib && csr_addr == A_MODE) ? apply_op(csr_op, m_mode[k][i], b) : m_mode[k][i];
            ne = (in_nib && csr_addr == A_MIE) ? apply_op(csr_op, m_mie[k][i], b) : m_mie[k][i];
            e  = m_edge[k][i];
            if (in_nib && csr_addr == A_MIP && m_mode[k][i]) e = apply_op(csr_op, e, b);
            if (ack && win == i && m_mode[k][i]) e = 1'b0;
            if (m_mode[k][i] && irq_in[i] && !m_last[k][i]) e = 1'b1;
            if (!nm) e = 1'b0;
            m_mode[k][i] = nm;
            m_mie[k][i]  = ne;
            m_edge[k][i] = e;
            m_last[k][i] = irq_in[i];
          end
          if (ack) begin
            m_cause[k] = (win >= 0) ? 5'(win) : 5'd0;
            m_cv[k]    = (win >= 0);
          end
        end
      end
      exp_q.push_back(w);
    end
  end

  // Scoreboard monitor: compares every predicted cycle against both DUTs.
  initial begin : monitor
    logic [21:0] e, a;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {rd32, pend32, cv32, cause32, rd16, pend16, cv16, cause16};
        vectors++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic tick();
    @(negedge clk);
    counter = counter + 3'd1;
  endtask

  task automatic sync0();
    while (counter != 3'd0) tick();
  endtask

  task automatic csr_instr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    csr_op = 2'b00;
    sync0();
    for (int c = 0; c < 8; c++) begin
      csr_addr = addr; csr_op = op; csr_wdata = data[4*c +: 4];
      tick();
    end
    csr_op = 2'b00;
  endtask

  task automatic read_chk(input string name, input logic [11:0] addr,
                          input logic [31:0] e16, input logic [31:0] e32);
    csr_op = 2'b00;
    sync0();
    for (int c = 0; c < 8; c++) begin
      csr_addr = addr; csr_op = 2'b10; csr_wdata = 4'h0;
      #4;
      chk({name, "_16"}, 32'(rd16), 32'(e16[4*c +: 4]));
      chk({name, "_32"}, 32'(rd32), 32'(e32[4*c +: 4]));
      tick();
    end
    csr_op = 2'b00;
  endtask

  task automatic do_ack();
    sync0();
    take_irq = 1'b1;
    tick();
    take_irq = 1'b0;
  endtask

  initial begin : stimulus
    logic [31:0] data;
    int          rst_at;
    rstn = 1'b0; counter = 3'd0; irq_in = '0; global_ie = 1'b0;
    csr_addr = 12'h0; csr_op = 2'b00; csr_wdata = 4'h0; take_irq = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    #4;
    chk("reset_cause", 32'(cause16), 32'd0);
    chk("reset_valid", 32'(cv16), 32'd0);
    chk("reset_pending", 32'(pend16), 32'd0);
    tick();

    // Edge channel 2 raises, is acknowledged and auto-cleared.
    csr_instr(A_MIE, 2'b01, 32'h4);
    csr_instr(A_MODE, 2'b10, 32'h4);
    global_ie = 1'b1;
    irq_in[2] = 1'b1;
    #4 chk("edge_not_yet", 32'(pend16), 32'd0);
    tick();
    #4 chk("edge_pending", 32'(pend16), 32'd1);
    do_ack();
    #4;
    chk("ack2_cause", 32'(cause16), 32'd2);
    chk("ack2_valid", 32'(cv16), 32'd1);
    read_chk("mip_after_ack2", A_MIP, 32'h0, 32'h0);

    // Level channel 5 stays pending until its line drops.
    csr_instr(A_MODE, 2'b11, 32'h20);
    csr_instr(A_MIE, 2'b10, 32'h20);
    irq_in[5] = 1'b1;
    do_ack();
    #4;
    chk("ack5_cause", 32'(cause16), 32'd5);
    chk("level_held", 32'(pend16), 32'd1);
    tick(); tick();
    #4 chk("level_still", 32'(pend16), 32'd1);
    irq_in[5] = 1'b0;
    tick();
    #4 chk("level_dropped", 32'(pend16), 32'd0);

    // Two edge channels: priority order, then nothing left.
    csr_instr(A_MODE, 2'b10, 32'h88);
    csr_instr(A_MIE, 2'b10, 32'h88);
    irq_in[3] = 1'b1; irq_in[7] = 1'b1;
    tick();
    irq_in[3] = 1'b0; irq_in[7] = 1'b0;
    do_ack();
    #4 chk("prio_first", 32'(cause16), 32'd3);
    do_ack();
    #4;
    chk("prio_second", 32'(cause16), 32'd7);
    chk("prio_second_valid", 32'(cv16), 32'd1);
    do_ack();
    #4;
    chk("none_valid", 32'(cv16), 32'd0);
    chk("none_cause", 32'(cause16), 32'd0);

    // Software clear of MIP bit 0 coincides with a hardware edge: set wins.
    sync0();
    csr_addr = A_MIP; csr_op = 2'b11; csr_wdata = 4'h1; irq_in[0] = 1'b1;
    tick();
    for (int c = 1; c < 8; c++) begin
      csr_wdata = 4'h0;
      tick();
    end
    csr_op = 2'b00;
    read_chk("mip_set_wins", A_MIP, 32'h1, 32'h1);

    // Top channel on the 32-channel instance, and upper nibbles on the 16-channel one.
    csr_instr(A_MODE, 2'b10, 32'h8000_0000);
    csr_instr(A_MIE, 2'b10, 32'h8000_0000);
    csr_instr(A_MIP, 2'b10, 32'h8000_0000);
    do_ack();
    #4;
    chk("ack31_cause", 32'(cause32), 32'd31);
    chk("ack31_valid", 32'(cv32), 32'd1);
    chk("ack31_narrow_valid", 32'(cv16), 32'd0);
    read_chk("mie_read", A_MIE, 32'h0000_00AC, 32'h8000_00AC);
    read_chk("mode_read", A_MODE, 32'h0000_008F, 32'h8000_008F);
    read_chk("unmapped_read", A_NONE, 32'h0, 32'h0);

    // Reset dropped in the middle of an MIE write.
    sync0();
    csr_addr = A_MIE; csr_op = 2'b01; csr_wdata = 4'hF;
    tick(); tick();
    rstn = 1'b0;
    #4;
    chk("midrst_cause", 32'(cause32), 32'd0);
    chk("midrst_valid", 32'(cv32), 32'd0);
    chk("midrst_pending", 32'(pend32), 32'd0);
    chk("midrst_rdata", 32'(rd16), 32'd0);
    tick(); tick();
    rstn = 1'b1;
    csr_op = 2'b00;
    read_chk("mie_after_rst", A_MIE, 32'h0, 32'h0);

    // Randomised instruction blocks, line toggles, acknowledges and the odd reset.
    for (int blk = 0; blk < 400; blk++) begin
      case ($urandom_range(0, 3))
        0:       csr_addr = A_MIE;
        1:       csr_addr = A_MIP;
        2:       csr_addr = A_MODE;
        default: csr_addr = A_NONE;
      endcase
      csr_op    = 2'($urandom_range(0, 3));
      data      = $urandom;
      global_ie = ($urandom_range(0, 7) != 0);
      rst_at    = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 7)) : 8;
      for (int c = 0; c < 8; c++) begin
        csr_wdata = data[4*c +: 4];
        if ($urandom_range(0, 2) == 0) irq_in = irq_in ^ (32'h1 << $urandom_range(0, 31));
        take_irq = (c == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
        rstn = (c != rst_at);
        tick();
      end
      rstn = 1'b1;
    end

    csr_op = 2'b00; take_irq = 1'b0;
    tick(); tick();
    #4 chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
